inv_sub_bytes_seq: RTL and testbench
====================================

// Module: inv_sub_bytes_seq
// PURPOSE
//  AES InvSubBytes over a full 128-bit state: inverse affine transform, then GF(2^8) multiplicative inverse.
//  Inverse of the existing forward SubB byte path.
//  Byte-serial engine: LANES bytes per clock through LANES shared GF_MULINV_8 instances.
//  Sits in the decryption round datapath between InvShiftRows and AddRoundKey.
//  Valid/ready handshake on both sides.
// PARAMETERS
//  LANES   4   bytes substituted per clock; legal 1,2,4,8,16 (other values -> elaboration error)
// PORTS
//  clk        in   1    system clock, rising edge
//  rst        in   1    asynchronous, active-high reset
//  in_valid   in   1    in_state valid
//  in_ready   out  1    block idle, can accept a state
//  in_state   in   128  ciphertext-side state; byte i = bits[8i+7:8i]
//  out_valid  out  1    out_state holds a finished result
//  out_ready  in   1    consumer accepts out_state
//  out_state  out  128  InvSubBytes(in_state), same byte ordering
//  busy       out  1    high while substitution in progress
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE, in_ready=1, out_valid=0, busy=0, out_state=0, byte counter=0.
//  Per-byte function: t_i = b[(i+2)%8]^b[(i+5)%8]^b[(i+7)%8]^c_i, c=8'h05; result=GF_MULINV_8(t).
//    GF_MULINV_8 maps 0 to 0. Purely combinational per lane; no register inside a lane.
//  N = 16/LANES groups; counter width clog2(N) (min 1); group g = bytes g*LANES .. g*LANES+LANES-1.
//  FSM IDLE -> BUSY -> DONE -> IDLE:
//   IDLE: in_ready=1. Transfer on in_valid&in_ready: latch in_state into the working register,
//     counter=0, go BUSY. in_valid without a transfer has no effect.
//   BUSY: in_ready=0, busy=1. Each edge replaces group[counter] in place, counter++.
//     On the edge that writes group N-1: counter wraps to 0, go DONE.
//   DONE: out_valid=1, out_state=working register, held stable while out_ready=0.
//     On out_valid&out_ready: go IDLE, out_valid=0 next cycle.
//  Latency: transfer edge k -> out_valid high after edge k+N (LANES=16: one cycle).
//  Throughput: one state per N+2 cycles. No overlap: in_ready stays 0 in DONE even if out_ready=1.
//  in_state changes after acceptance have no effect. out_ready in IDLE/BUSY is ignored.
//  Reset mid-operation: result discarded, outputs return to reset values immediately (async).
//  out_state is the register, not a combinational path; it changes only on edges in BUSY.
// STRUCTURE
//  Shared AES package holds:
//    AES_AFFINE_C=8'h63 and AES_INV_AFFINE_C=8'h05
//    inv_affine() function, beside the forward mat_at affine
//    FSM state encoding constants
//  Reuse existing GF_MULINV_8 (x->y ports), generate-instantiated LANES times.
//  Lane mux selects group[counter]. Natural sub-module: inv_sbox_byte (inv_affine + GF_MULINV_8), one per lane.
// TESTING
//  1 Single bytes, LANES=1, one per state slot:
//    state of all 8'h63 -> all 8'h00; 8'h7C -> 8'h01; 8'h00 -> 8'h52;
//    8'h16 -> 8'hFF; 8'hED -> 8'h53.
//  2 Mixed state, every LANES value:
//    in_state=128'h16ED7C63_00000000_7C7C6363_ED1600FF
//    -> out_state=128'hFF530100_52525252_01010000_53FF527D.
//    out_valid exactly N cycles after the accepting edge.
//  3 Round trip: 256 random states through forward SubB per byte, then this block -> original state restored.
//    Also exhaustive 0..255 byte sweep against a golden inverse table.
//  4 Backpressure: hold out_ready=0 for 10 cycles in DONE.
//    -> out_state/out_valid stable, in_ready=0, second in_valid not accepted until after out handshake.
//  5 Async reset asserted mid-BUSY (counter=2, LANES=4) between edges.
//    -> busy=0, out_valid=0, in_ready=1 immediately; next state processes correctly from byte 0.
//  6 in_valid=1 every cycle with out_ready=1 -> exactly one acceptance per N+2 cycles, no lost or duplicated states.

Source files
------------

// File: rtl/inv_sub_bytes_seq_pkg.sv
// Shared AES byte-path definitions: affine constants, forward/inverse affine
// transforms and the legacy-compatible FSM state encoding.
package inv_sub_bytes_seq_pkg;

  typedef logic [7:0]   aes_byte_t;
  typedef logic [127:0] aes_state_t;

  localparam aes_byte_t AES_AFFINE_C     = 8'h63;
  localparam aes_byte_t AES_INV_AFFINE_C = 8'h05;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Forward SubBytes affine, applied after the field inverse.
  function automatic aes_byte_t mat_at(input aes_byte_t b);
    aes_byte_t s;
    for (int unsigned i = 0; i < 8; i++) begin
      s[i] = b[i] ^ b[3'(i + 4)] ^ b[3'(i + 5)] ^ b[3'(i + 6)] ^ b[3'(i + 7)]
             ^ AES_AFFINE_C[i];
    end
    return s;
  endfunction

  // Inverse affine, applied before the field inverse.
  function automatic aes_byte_t inv_affine(input aes_byte_t b);
    aes_byte_t t;
    for (int unsigned i = 0; i < 8; i++) begin
      t[i] = b[3'(i + 2)] ^ b[3'(i + 5)] ^ b[3'(i + 7)] ^ AES_INV_AFFINE_C[i];
    end
    return t;
  endfunction

endpackage

// File: rtl/inv_sub_bytes_seq_if.sv
// Valid/ready handshake bundle for the InvSubBytes engine: state in, result out.
interface inv_sub_bytes_seq_if;
  import inv_sub_bytes_seq_pkg::*;

  logic       in_valid;
  logic       in_ready;
  aes_state_t in_state;
  logic       out_valid;
  logic       out_ready;
  aes_state_t out_state;

  modport master (
    output in_valid, in_state, out_ready,
    input  in_ready, out_valid, out_state
  );

  modport slave (
    input  in_valid, in_state, out_ready,
    output in_ready, out_valid, out_state
  );
endinterface

// File: rtl/GF_MULINV_8.sv
// Combinational GF(2^8) multiplicative inverse (AES polynomial 0x11B), 0 -> 0.
module GF_MULINV_8 (
  input  logic [7:0] x,
  output logic [7:0] y
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] sq;
  logic [7:0] acc;

  // x^254 = x^2 * x^4 * ... * x^128, which also yields 0 for x = 0.
  always_comb begin
    sq  = x;
    acc = 8'h01;
    for (int unsigned i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    y = acc;
  end

endmodule

// File: rtl/inv_sbox_byte.sv
// One InvSubBytes lane: inverse affine followed by the field inverse, no state.
module inv_sbox_byte
  import inv_sub_bytes_seq_pkg::*;
(
  input  aes_byte_t b_i,
  output aes_byte_t s_o
);

  aes_byte_t t;

  assign t = inv_affine(b_i);

  GF_MULINV_8 u_inv (
    .x (t),
    .y (s_o)
  );

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Byte-serial AES InvSubBytes: LANES bytes substituted in place per clock,
// result held in the working register until the consumer takes it.
module inv_sub_bytes_seq #(
  parameter int unsigned LANES = 4
) (
  input  logic                clk,
  input  logic                rst,
  inv_sub_bytes_seq_if.slave  bus,
  output logic                busy
);
  import inv_sub_bytes_seq_pkg::*;

  localparam int unsigned N  = 16 / LANES;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned GW = 8 * LANES;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  aes_state_t    work_q, work_d;

  logic [6:0]    base;
  logic [GW-1:0] grp_in;
  logic [GW-1:0] grp_out;

  assign base   = 7'(cnt_q * GW);
  assign grp_in = work_q[base +: GW];

  for (genvar l = 0; l < int'(LANES); l++) begin : g_lane
    inv_sbox_byte u_lane (
      .b_i (grp_in[8*l +: 8]),
      .s_o (grp_out[8*l +: 8])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          work_d  = bus.in_state;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        work_d[base +: GW] = grp_out;
        if (cnt_q == CW'(N - 1)) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.out_state = work_q;
  assign busy          = (state_q == ST_BUSY);

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Directed bench for inv_sub_bytes_seq: one instance per legal LANES value,
// scoreboard of expected states built from an independent S-box table.
module tb_inv_sub_bytes_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [4:0]   iv, ordy;
  logic [127:0] st [5];
  logic [4:0]   ov, ir, bz;
  logic [127:0] os [5];

  // Instance k has LANES = 1 << k.
  for (genvar k = 0; k < 5; k++) begin : g_dut
    inv_sub_bytes_seq_if ifc ();
    assign ifc.in_valid  = iv[k];
    assign ifc.in_state  = st[k];
    assign ifc.out_ready = ordy[k];
    assign ov[k] = ifc.out_valid;
    assign ir[k] = ifc.in_ready;
    assign os[k] = ifc.out_state;
    inv_sub_bytes_seq #(.LANES(1 << k)) u_dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (ifc),
      .busy (bz[k])
    );
  end

  int errors = 0;
  int checks = 0;

  logic [127:0] sbox_rows [16];
  logic [7:0]   inv_tab [256];
  logic [127:0] sb [$];
  logic [127:0] exp_in;
  int  cyc_n = 0, acc_t = 0, acc_cnt = 0, rel_cnt = 0;
  bit  got_acc, got_rel, ovp;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] sbox_f(input logic [7:0] v);
    logic [127:0] r;
    r = sbox_rows[v[7:4]];
    return r[8*(15 - v[3:0]) +: 8];
  endfunction

  function automatic logic [127:0] golden(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_tab[s[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] fwd(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox_f(s[8*i +: 8]);
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // One clock of instance k: log handshakes completing on this edge, then
  // check out_valid rises exactly N edges after the accepting edge.
  task automatic cyc(input int k);
    bit a, r;
    a = iv[k] && ir[k];
    r = ov[k] && ordy[k];
    if (r) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_output: observed=%h expected=none", os[k]);
      end
      if (sb.size() != 0) chk("out_state", os[k], sb.pop_front());
      rel_cnt++;
    end
    if (a) begin
      sb.push_back(exp_in);
      acc_t = cyc_n + 1;
      acc_cnt++;
    end
    got_acc = a;
    got_rel = r;
    @(posedge clk);
    #1;
    cyc_n++;
    if (ov[k] && !ovp) chk_i("latency", cyc_n - acc_t, 16 >> k);
    ovp = ov[k];
  endtask

  task automatic xfer(input int k, input logic [127:0] s, input logic [127:0] e);
    bit ok;
    ovp = ov[k];
    st[k] = s; exp_in = e; iv[k] = 1'b1; ordy[k] = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      cyc(k);
      if (got_acc) begin ok = 1'b1; break; end
    end
    iv[k] = 1'b0;
    chk_i("accept_timeout", int'(ok), 1);
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      cyc(k);
      if (got_rel) begin ok = 1'b1; break; end
    end
    chk_i("release_timeout", int'(ok), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]   t1_in [5];
    logic [7:0]   t1_ex [5];
    logic [127:0] x, y, s;
    bit           ok;
    int           prev;

    sbox_rows = '{
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    for (int v = 0; v < 256; v++) inv_tab[sbox_f(8'(v))] = 8'(v);

    rst = 1'b1; iv = '0; ordy = '0; exp_in = '0;
    for (int k = 0; k < 5; k++) st[k] = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      chk_i("reset_in_ready", int'(ir[k]), 1);
      chk_i("reset_out_valid", int'(ov[k]), 0);
      chk_i("reset_busy", int'(bz[k]), 0);
      chk("reset_out_state", os[k], '0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single-byte patterns on LANES=1, replicated over every state slot.
    t1_in = '{8'h63, 8'h7C, 8'h00, 8'h16, 8'hED};
    t1_ex = '{8'h00, 8'h01, 8'h52, 8'hFF, 8'h53};
    for (int i = 0; i < 5; i++) xfer(0, {16{t1_in[i]}}, {16{t1_ex[i]}});

    // Mixed state on every LANES value.
    for (int k = 0; k < 5; k++)
      xfer(k, 128'h16ED7C63_00000000_7C7C6363_ED1600FF,
              128'hFF530100_52525252_01010000_53FF527D);

    // Round trip through the forward S-box, then exhaustive byte sweep.
    for (int i = 0; i < 256; i++) begin
      x = rnd128();
      xfer(2, fwd(x), x);
    end
    for (int j = 0; j < 16; j++) begin
      for (int i = 0; i < 16; i++) s[8*i +: 8] = 8'(16 * j + i);
      xfer(2, s, golden(s));
    end

    // Backpressure in DONE with a second state already waiting.
    x = rnd128(); y = rnd128();
    ovp = ov[2]; acc_cnt = 0;
    st[2] = x; exp_in = golden(x); iv[2] = 1'b1; ordy[2] = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cyc(2);
      if (got_acc) begin ok = 1'b1; break; end
    end
    chk_i("bp_accept", int'(ok), 1);
    st[2] = y; exp_in = golden(y);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (ov[2]) begin ok = 1'b1; break; end
      cyc(2);
    end
    chk_i("bp_done", int'(ok), 1);
    for (int c = 0; c < 10; c++) begin
      cyc(2);
      chk_i("bp_out_valid", int'(ov[2]), 1);
      chk_i("bp_in_ready", int'(ir[2]), 0);
      chk("bp_out_state", os[2], golden(x));
      chk_i("bp_accepts", acc_cnt, 1);
    end
    ordy[2] = 1'b1;
    cyc(2);
    chk_i("bp_released", int'(got_rel), 1);
    chk_i("bp_out_valid_low", int'(ov[2]), 0);
    chk_i("bp_accepts_after_rel", acc_cnt, 1);
    cyc(2);
    chk_i("bp_second_accept", int'(got_acc), 1);
    iv[2] = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      cyc(2);
      if (got_rel) begin ok = 1'b1; break; end
    end
    chk_i("bp_second_release", int'(ok), 1);

    // Asynchronous reset with the counter at 2 on LANES=4.
    ovp = ov[2];
    st[2] = rnd128(); exp_in = golden(st[2]); iv[2] = 1'b1;
    cyc(2);
    chk_i("rst_accept", int'(got_acc), 1);
    iv[2] = 1'b0;
    cyc(2);
    cyc(2);
    chk_i("rst_busy_before", int'(bz[2]), 1);
    #2 rst = 1'b1;
    #1;
    chk_i("rst_busy", int'(bz[2]), 0);
    chk_i("rst_out_valid", int'(ov[2]), 0);
    chk_i("rst_in_ready", int'(ir[2]), 1);
    chk("rst_out_state", os[2], '0);
    #1 rst = 1'b0;
    sb.delete();
    xfer(2, 128'h16ED7C63_00000000_7C7C6363_ED1600FF,
            128'hFF530100_52525252_01010000_53FF527D);

    // Continuous in_valid with out_ready high: one acceptance per N+2 edges.
    acc_cnt = 0; rel_cnt = 0; prev = 0; ovp = ov[2];
    st[2] = rnd128(); exp_in = golden(st[2]); iv[2] = 1'b1; ordy[2] = 1'b1;
    for (int c = 0; c < 60; c++) begin
      cyc(2);
      if (got_acc) begin
        if (acc_cnt > 1) chk_i("accept_spacing", acc_t - prev, 6);
        prev = acc_t;
        st[2] = rnd128(); exp_in = golden(st[2]);
      end
    end
    iv[2] = 1'b0;
    chk_i("stream_accepts", acc_cnt, 10);
    chk_i("stream_releases", rel_cnt, 10);
    chk_i("stream_pending", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
